// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX stream arbiter and its pickers.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // Channel-index width; never below one bit so a 2-channel build still has an index.
  function automatic int ch_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester searching upward from ptr+1 with wrap.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_any
);

  // Walk the search order backwards so the nearest requester after ptr is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NUM_CH]) begin
        gnt_idx = CH_W'((int'(ptr) + k) % NUM_CH);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one byte-wide TX stream between NUM_CH sources.
// state   | meaning
// IDLE    | no owner; pick next requester after rr_ptr
// HDR     | present channel tag byte {HDR_TAG, grant_ch}
// DATA    | pass granted channel through until its s_last transfer
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter bit  ID_EN  = 1'b1,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH*8-1:0]   s_data,
  input  logic [NUM_CH-1:0]     s_valid,
  input  logic [NUM_CH-1:0]     s_last,
  output logic [NUM_CH-1:0]     s_ready,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CH_W-1:0]       grant_ch,
  output logic                  busy
);

  arb_state_t      state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0] pick_idx;
  logic            pick_any;
  logic [7:0]      g_data;
  logic            g_valid;
  logic            g_last;

  rr_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .req     (s_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == CH_W'(i)) begin
        g_data  = s_data[8*i +: 8];
        g_valid = s_valid[i];
        g_last  = s_last[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ID_EN ? ST_HDR : ST_DATA;
        end
      end
      ST_HDR: begin
        if (m_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (g_valid && m_ready && g_last) begin
          rr_ptr_d = grant_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode only registered state; m_ready reaches s_ready but never m_valid.
  always_comb begin
    m_data  = '0;
    m_valid = 1'b0;
    s_ready = '0;
    case (state_q)
      ST_HDR: begin
        m_data  = {HDR_TAG, 4'(grant_q)};
        m_valid = 1'b1;
      end
      ST_DATA: begin
        m_data  = g_data;
        m_valid = g_valid;
        for (int i = 0; i < NUM_CH; i++) begin
          if (grant_q == CH_W'(i)) s_ready[i] = m_ready;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= CH_W'(NUM_CH - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant_ch = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic [3:0]  s_last, sv, sv1, sv0;
  logic [3:0]  sr1, sr0;
  logic [7:0]  md1, md0;
  logic        mv1, mv0, busy1, busy0;
  logic [1:0]  gc1, gc0;
  logic        m_ready;
  logic        sel;

  logic [3:0]  a_sr;
  logic [7:0]  a_md;
  logic        a_mv, a_busy;

  int n_chk = 0;
  int n_fail = 0;

  // per-channel source queues: byte, last flag, valid-low cycles before this byte
  logic [7:0] bq[4][$];
  bit         lq[4][$];
  int         dq[4][$];
  int         wcnt[4];
  int         sr_cnt[4];
  int         first_mv;
  int         ptr1, ptr0;

  logic [7:0] exp_d[$];
  bit         exp_t[$];
  bit         exp_l[$];

  always #5 clk = ~clk;

  assign sv1    = sel ? sv : 4'b0;
  assign sv0    = sel ? 4'b0 : sv;
  assign a_sr   = sel ? sr1 : sr0;
  assign a_md   = sel ? md1 : md0;
  assign a_mv   = sel ? mv1 : mv0;
  assign a_busy = sel ? busy1 : busy0;

  uart_tx_arbiter #(.NUM_CH(4), .ID_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(sv1), .s_last(s_last),
    .s_ready(sr1), .m_data(md1), .m_valid(mv1), .m_ready(m_ready),
    .grant_ch(gc1), .busy(busy1)
  );

  uart_tx_arbiter #(.NUM_CH(4), .ID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(sv0), .s_last(s_last),
    .s_ready(sr0), .m_data(md0), .m_valid(mv0), .m_ready(m_ready),
    .grant_ch(gc0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_byte(input int c, input logic [7:0] d, input bit l, input int dly);
    bq[c].push_back(d);
    lq[c].push_back(l);
    dq[c].push_back(dly);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    sv  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ptr1 = 3;
    ptr0 = 3;
  endtask

  // Expected output stream: whole packets in round-robin order from ptr+1, tag first if enabled.
  task automatic build_exp(input bit id_en, inout int ptr);
    logic [7:0] mb[4][$];
    bit         ml[4][$];
    int         pick;
    bit         l;
    exp_d.delete();
    exp_t.delete();
    exp_l.delete();
    for (int c = 0; c < 4; c++) begin
      mb[c] = bq[c];
      ml[c] = lq[c];
    end
    forever begin
      pick = -1;
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && mb[(ptr + k) % 4].size() > 0) pick = (ptr + k) % 4;
      if (pick < 0) break;
      if (id_en) begin
        exp_d.push_back(8'hA0 + 8'(pick));
        exp_t.push_back(1'b1);
        exp_l.push_back(1'b0);
      end
      do begin
        exp_d.push_back(mb[pick].pop_front());
        l = ml[pick].pop_front();
        exp_t.push_back(1'b0);
        exp_l.push_back(l);
      end while (!l && mb[pick].size() > 0);
      ptr = pick;
    end
  endtask

  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      if (bq[c].size() > 0) begin
        s_data[8*c +: 8] = bq[c][0];
        s_last[c]        = lq[c][0];
        sv[c]            = (wcnt[c] == 0);
      end else begin
        s_data[8*c +: 8] = '0;
        s_last[c]        = 1'b0;
        sv[c]            = 1'b0;
      end
    end
  endtask

  // mode 0: m_ready always high; 1: random; 2: one cycle high then 20 low
  task automatic run_traffic(input int mode, input int budget);
    int         oidx = 0;
    int         cyc = 0;
    int         mr_ph = 0;
    int         exp_n;
    int         left;
    bit         prev_stall = 0;
    bit         prev_last = 0;
    logic [7:0] prev_md = '0;
    logic [3:0] hs;
    bit         was_last;
    if (sel) build_exp(1'b1, ptr1);
    else     build_exp(1'b0, ptr0);
    exp_n = exp_d.size();
    first_mv = -1;
    for (int c = 0; c < 4; c++) begin
      wcnt[c]   = 0;
      sr_cnt[c] = 0;
    end
    @(posedge clk); #1;
    drive();
    m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom % 3 != 0) : 1'b1;
    mr_ph = 1;
    while (cyc < budget && (oidx < exp_n || a_busy)) begin
      @(negedge clk);
      if (a_mv && first_mv < 0) first_mv = cyc;
      if (prev_stall) begin
        chk("hold_valid", a_mv, 1);
        chk("hold_data", a_md, prev_md);
      end
      if (prev_last) chk("pkt_gap", a_mv, 0);
      hs = sv & a_sr;
      for (int c = 0; c < 4; c++) sr_cnt[c] += a_sr[c];
      if (a_mv && m_ready) begin
        if (oidx < exp_n) begin
          chk("m_data", a_md, exp_d[oidx]);
          chk("s_hs", $countones(hs), exp_t[oidx] ? 0 : 1);
          prev_last = exp_l[oidx];
        end else begin
          prev_last = 1'b0;
        end
        oidx++;
      end else begin
        chk("s_hs_idle", $countones(hs), 0);
        prev_last = 1'b0;
      end
      prev_stall = a_mv && !m_ready;
      prev_md    = a_md;
      @(posedge clk); #1;
      cyc++;
      for (int c = 0; c < 4; c++) begin
        if (hs[c]) begin
          was_last = lq[c][0];
          void'(bq[c].pop_front());
          void'(lq[c].pop_front());
          void'(dq[c].pop_front());
          wcnt[c] = (!was_last && dq[c].size() > 0) ? dq[c][0] : 0;
        end else if (wcnt[c] > 0) begin
          wcnt[c]--;
        end
      end
      drive();
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom % 3 != 0);
        default: begin
          m_ready = (mr_ph == 0);
          mr_ph   = (mr_ph + 1) % 21;
        end
      endcase
    end
    left = 0;
    for (int c = 0; c < 4; c++) left += bq[c].size();
    chk("timeout", (cyc >= budget), 0);
    chk("byte_count", oidx, exp_n);
    chk("drained", left, 0);
    if (exp_n > 0) chk("arb_latency", first_mv, 1);
    m_ready = 1'b0;
  endtask

  task automatic load_random();
    int np, len;
    for (int c = 0; c < 4; c++) begin
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++)
          add_byte(c, 8'($urandom), b == len - 1,
                   (b == 0) ? 0 : (($urandom % 3 == 0) ? $urandom_range(1, 4) : 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1; sv = '0; s_data = '0; s_last = '0; m_ready = 1'b0; sel = 1'b1;
    for (int c = 0; c < 4; c++) wcnt[c] = 0;
    do_reset();

    @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_m_valid", mv1, 0);
    chk("rst_m_data", md1, 0);
    chk("rst_s_ready", sr1, 0);
    chk("rst_grant", gc1, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_s_ready0", sr0, 0);

    // ch2 two-byte packet, tag on
    sel = 1'b1;
    add_byte(2, 8'h11, 1'b0, 0);
    add_byte(2, 8'h22, 1'b1, 0);
    run_traffic(0, 200);
    chk("sready2_cycles", sr_cnt[2], 2);

    // all four single-byte packets at once, tag off
    do_reset();
    sel = 1'b0;
    for (int c = 0; c < 4; c++) add_byte(c, 8'h40 + 8'(c), 1'b1, 0);
    run_traffic(0, 200);

    // back-pressure in the uart_fsm pattern
    sel = 1'b1;
    add_byte(1, 8'h31, 1'b0, 0);
    add_byte(1, 8'h32, 1'b0, 0);
    add_byte(1, 8'h33, 1'b1, 0);
    run_traffic(2, 500);

    // lock: ch0 stalls 5 cycles mid-packet while ch3 waits
    do_reset();
    add_byte(0, 8'h01, 1'b0, 0);
    add_byte(0, 8'h02, 1'b0, 5);
    add_byte(0, 8'h03, 1'b1, 0);
    add_byte(3, 8'h77, 1'b1, 0);
    run_traffic(0, 300);

    // mid-packet reset during ch1 DATA
    @(posedge clk); #1;
    sv = 4'b0010; s_data = 32'h0000_5500; s_last = '0; m_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_rst_busy", busy1, 1);
    chk("pre_rst_sready", sr1, 4'b0010);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ptr1 = 3;
    @(negedge clk);
    chk("post_rst_busy", busy1, 0);
    chk("post_rst_m_valid", mv1, 0);
    chk("post_rst_s_ready", sr1, 0);
    sv = '0; s_data = '0; m_ready = 1'b0;
    add_byte(0, 8'h10, 1'b1, 0);
    add_byte(1, 8'h21, 1'b1, 0);
    run_traffic(0, 200);

    // randomized traffic on both variants, rr pointer carried across runs
    for (int it = 0; it < 6; it++) begin
      sel = it[0];
      load_random();
      run_traffic(it % 3, 20000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single byte-wide TX stream of `uart_fsm` (`tx_data`/`tx_data_valid`/`tx_data_ready`) between `NUM_CH` packet sources. It locks the grant for a whole packet, delimited by `s_last`. When `ID_EN=1` it prepends one channel-tag byte per packet so the host can demultiplex. It sits between the per-function stream producers and the `uart_fsm` TX port.

## Interface
- `NUM_CH`, 4: number of requesters, range 2..16.
- `ID_EN`, 1: 1 = emit tag byte `{4'hA, ch[3:0]}` before each packet; 0 = no tag.
- `CH_W`, derived `$clog2(NUM_CH)`: width of the channel index.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `s_data`  in  `NUM_CH*8`  byte per channel; channel i occupies bits `[8i+7:8i]`.
- `s_valid`  in  `NUM_CH`  per-channel byte valid.
- `s_last`  in  `NUM_CH`  per-channel end-of-packet, qualified by `s_valid`.
- `s_ready`  out  `NUM_CH`  per-channel accept.
- `m_data`  out  8  byte to `uart_fsm.tx_data`.
- `m_valid`  out  1  to `uart_fsm.tx_data_valid`.
- `m_ready`  in  1  from `uart_fsm.tx_data_ready`.
- `grant_ch`  out  `CH_W`  channel currently owning the stream.
- `busy`  out  1  high while in HDR or DATA.

## Operation
- Transfer occurs on any cycle with valid && ready, on both the s side and the m side. Sources must hold data/last stable until accepted.
- State machine:
  - **IDLE**: `m_valid=0`, `s_ready=0`. If any `s_valid` is high, pick the first requesting channel searching upward from `rr_ptr+1` with wrap, and register it into `grant_ch`. Next state is HDR if `ID_EN`, otherwise DATA.
  - **HDR**: `m_data={4'hA,grant_ch}` (zero-extended), `m_valid=1`, all `s_ready=0`. On `m_ready`, go to DATA.
  - **DATA**: combinational pass-through of the granted channel only.
    - `m_data=s_data[g]`, `m_valid=s_valid[g]`, `s_ready[g]=m_ready`; all other `s_ready=0`.
    - On a transfer with `s_last[g]=1`: set `rr_ptr<=grant_ch` and go to IDLE.
- The grant never changes mid-packet. A `s_valid[g]` gap inside a packet stalls the stream and does not release the grant.
- Requests from non-granted channels during HDR/DATA are ignored until the next IDLE.
- Single-byte packet (`s_last` on the first byte) is legal. It yields tag + 1 byte, or 1 byte when `ID_EN=0`.
- No combinational path from `m_ready` to `m_valid`.

## Timing
- Reset values: state IDLE, `rr_ptr=NUM_CH-1` (channel 0 wins first), `grant_ch=0`, `busy=0`, `m_valid=0`, `m_data=0`, `s_ready=0`.
- Arbitration latency: 1 cycle from `s_valid` rising in IDLE to `m_valid` rising (tag byte or first data byte).
- Minimum packet gap: 1 IDLE cycle between the `s_last` transfer and the next packet's first `m_valid`.
- Throughput is bounded by `uart_fsm`. `m_ready` drops for the full serialization time of each byte, and the arbiter simply holds.
- `rst` asserted mid-packet: return to the reset state on the next edge. The partial packet is abandoned; no tag or trailer is emitted.
- `s_valid[g]` deasserts in DATA: `m_valid=0` that cycle, no state change.
- Simultaneous requests from all channels: service order is ptr+1, ptr+2, … with wrap. Each channel waits at most `NUM_CH-1` packets.

## Structure
- Package `uart_arb_pkg`:
  - state encoding `ST_IDLE=2'd0`, `ST_HDR=2'd1`, `ST_DATA=2'd2`;
  - `HDR_TAG=4'hA`;
  - function `ch_w(n)`.
- Sub-module `rr_picker`: combinational, with ports `req[NUM_CH]`, `ptr[CH_W]`, `gnt_idx[CH_W]`, `gnt_any`. It is reused by future RX-side demux schedulers.
- Top-level: FSM, `grant_ch`/`rr_ptr` registers, output muxing.

## Test plan
- **Single channel, `ID_EN=1`**: ch2 sends `0x11,0x22(last)` with `m_ready` always 1. `m_data` sequence is `0xA2,0x11,0x22`. `s_ready[2]` is high for exactly 2 cycles.
- **All 4 request at once after reset, `ID_EN=0`**: each sends a 1-byte packet with `data=0x40+ch`. Output is `0x40,0x41,0x42,0x43`, with one IDLE cycle between packets.
- **Back-pressure**: `m_ready` follows the `uart_fsm` pattern (1 cycle high, 20 low). A 3-byte packet on ch1 emits every byte exactly once. `m_data` stays stable while `m_valid && !m_ready`.
- **Lock**: ch0 packet in DATA with `s_valid[0]` gap of 5 cycles while ch3 requests. No ch3 byte appears until after ch0's last byte. Then tag `0xA3` is emitted.
- **Fairness**: ch0 requests continuously, ch1 requests once. ch1's packet starts within one ch0 packet of its request.
- **Mid-packet reset**: `rst` pulsed 1 cycle during ch1 DATA. Next cycle `busy=0`, `m_valid=0`, `s_ready=0`. The next request from ch0 is granted first.
